// File: rtl/cheat_pgm_loader.sv
// Byte-stream loader for the cheat/hook engine program port: packs big-endian
// 32-bit words and writes them to consecutive slots, yielding to pgm_block.
module cheat_pgm_loader #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_start,
    input  logic [2:0]  cmd_idx,
    input  logic [3:0]  cmd_count,
    input  logic        cmd_abort,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic        pgm_block,
    output logic [2:0]  pgm_idx,
    output logic [31:0] pgm_in,
    output logic        pgm_we,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_ISSUE   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    logic [1:0]  state_q,   state_d;
    logic [2:0]  slot_q,    slot_d;
    logic [3:0]  rem_q,     rem_d;
    logic [1:0]  bcnt_q,    bcnt_d;
    logic [15:0] wait_q,    wait_d;
    logic        err_q,     err_d;
    logic [31:0] pgm_in_q,  pgm_in_d;
    logic [2:0]  pgm_idx_q, pgm_idx_d;

    assign byte_ready = (state_q == S_COLLECT);
    assign busy       = (state_q == S_COLLECT) || (state_q == S_ISSUE);
    assign done       = (state_q == S_DONE);
    assign err        = err_q;
    assign pgm_in     = pgm_in_q;
    assign pgm_idx    = pgm_idx_q;

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path can infer a latch.
        state_d   = state_q;
        slot_d    = slot_q;
        rem_d     = rem_q;
        bcnt_d    = bcnt_q;
        wait_d    = wait_q;
        err_d     = err_q;
        pgm_in_d  = pgm_in_q;
        pgm_idx_d = pgm_idx_q;
        pgm_we    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (cmd_start) begin
                    if (cmd_count == 4'd0) begin
                        err_d   = 1'b0;
                        state_d = S_DONE;
                    end else if (cmd_count > 4'd8) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        slot_d  = cmd_idx;
                        rem_d   = cmd_count;
                        bcnt_d  = 2'd0;
                        state_d = S_COLLECT;
                    end
                end
            end

            S_COLLECT: begin
                if (cmd_start) err_d = 1'b1;
                if (cmd_abort) begin
                    bcnt_d  = 2'd0;
                    state_d = S_DONE;
                end else if (byte_valid) begin
                    case (bcnt_q)
                        2'd0:    pgm_in_d[31:24] = byte_in;
                        2'd1:    pgm_in_d[23:16] = byte_in;
                        2'd2:    pgm_in_d[15:8]  = byte_in;
                        default: pgm_in_d[7:0]   = byte_in;
                    endcase
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        pgm_idx_d = slot_q;
                        wait_d    = 16'd0;
                        state_d   = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                if (cmd_start) err_d = 1'b1;
                if (!pgm_block) begin
                    // The write is never suppressed by abort; abort only ends the load after it.
                    pgm_we  = 1'b1;
                    slot_d  = slot_q + 3'd1;
                    rem_d   = rem_q - 4'd1;
                    state_d = (rem_q == 4'd1 || cmd_abort) ? S_DONE : S_COLLECT;
                end else if (cmd_abort) begin
                    state_d = S_DONE;
                end else if (wait_q == TIMEOUT_W) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state_q   <= S_IDLE;
            slot_q    <= 3'd0;
            rem_q     <= 4'd0;
            bcnt_q    <= 2'd0;
            wait_q    <= 16'd0;
            err_q     <= 1'b0;
            pgm_in_q  <= 32'd0;
            pgm_idx_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            rem_q     <= rem_d;
            bcnt_q    <= bcnt_d;
            wait_q    <= wait_d;
            err_q     <= err_d;
            pgm_in_q  <= pgm_in_d;
            pgm_idx_q <= pgm_idx_d;
        end
    end

endmodule

// File: tb/tb_cheat_pgm_loader.sv
// Directed bench for cheat_pgm_loader: a default instance plus a TIMEOUT=4
// instance that only differs in its pgm_block input.
module tb_cheat_pgm_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_start, cmd_abort, byte_valid, pgm_block, pgm_block2;
    logic [2:0]  cmd_idx;
    logic [3:0]  cmd_count;
    logic [7:0]  byte_in;
    logic        byte_ready, pgm_we, busy, done, err;
    logic [2:0]  pgm_idx;
    logic [31:0] pgm_in;
    logic        byte_ready2, pgm_we2, busy2, done2, err2;
    logic [2:0]  pgm_idx2;
    logic [31:0] pgm_in2;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int acc_cyc, done_cyc, done_cnt, done2_cyc, done2_cnt, we2_cnt;
    logic [2:0]  we_idx_q[$];
    logic [31:0] we_dat_q[$];
    int          we_cyc_q[$];

    always #5 clk = ~clk;

    cheat_pgm_loader u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_idx(cmd_idx),
        .cmd_count(cmd_count), .cmd_abort(cmd_abort), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .pgm_block(pgm_block),
        .pgm_idx(pgm_idx), .pgm_in(pgm_in), .pgm_we(pgm_we), .busy(busy),
        .done(done), .err(err)
    );

    cheat_pgm_loader #(.TIMEOUT(4)) u_dut_to (
        .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_idx(cmd_idx),
        .cmd_count(cmd_count), .cmd_abort(cmd_abort), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready2), .pgm_block(pgm_block2),
        .pgm_idx(pgm_idx2), .pgm_in(pgm_in2), .pgm_we(pgm_we2), .busy(busy2),
        .done(done2), .err(err2)
    );

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (pgm_we) begin
            we_idx_q.push_back(pgm_idx);
            we_dat_q.push_back(pgm_in);
            we_cyc_q.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (byte_valid && byte_ready) acc_cyc = cyc;
        if (pgm_we2) we2_cnt++;
        if (done2) begin
            done2_cnt++;
            done2_cyc = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mon_clear();
        we_idx_q.delete();
        we_dat_q.delete();
        we_cyc_q.delete();
        done_cnt  = 0;
        done2_cnt = 0;
        we2_cnt   = 0;
    endtask

    task automatic start(input logic [2:0] idx, input logic [3:0] cnt);
        cmd_idx   = idx;
        cmd_count = cnt;
        cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic ok;
        ok         = 1'b0;
        byte_in    = b;
        byte_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            ok = byte_ready;
            step();
            if (ok) break;
        end
        byte_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL byte_accept: byte %h not accepted, ready=%b, required 1 within 40 cycles", b, byte_ready);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic wait_done(input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            found = done;
            step();
            if (found) break;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s_done: done=%b, required a pulse within 60 cycles", name, done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        @(negedge clk);
        checks += 7;
        if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        if (done !== 1'b0)       begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
        if (pgm_we !== 1'b0)     begin errors++; $display("FAIL reset_we: got %b, required 0", pgm_we); end
        if (err !== 1'b0)        begin errors++; $display("FAIL reset_err: got %b, required 0", err); end
        if (byte_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b, required 0", byte_ready); end
        if (pgm_in !== 32'd0)    begin errors++; $display("FAIL reset_pgm_in: got %h, required 0", pgm_in); end
        if (pgm_idx !== 3'd0)    begin errors++; $display("FAIL reset_pgm_idx: got %0d, required 0", pgm_idx); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        mon_clear();
        start(3'd2, 4'd1);
        send_word(32'h7E123499);
        wait_done("single");
        checks += 6;
        if (we_idx_q.size() !== 1) begin
            errors++; $display("FAIL single_we_count: got %0d, required 1", we_idx_q.size());
        end else begin
            if (we_idx_q[0] !== 3'd2) begin errors++; $display("FAIL single_idx: got %0d, required 2", we_idx_q[0]); end
            if (we_dat_q[0] !== 32'h7E123499) begin errors++; $display("FAIL single_data: got %h, required 7e123499", we_dat_q[0]); end
            if (we_cyc_q[0] !== acc_cyc + 1) begin errors++; $display("FAIL single_latency: we at %0d, required %0d", we_cyc_q[0], acc_cyc + 1); end
            if (done_cyc !== we_cyc_q[0] + 1) begin errors++; $display("FAIL single_done_cycle: got %0d, required %0d", done_cyc, we_cyc_q[0] + 1); end
        end
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b, required 0", busy); end
        if (pgm_in !== 32'h7E123499) begin errors++; $display("FAIL single_hold: got %h, required 7e123499", pgm_in); end
    endtask

    task automatic test_wrap();
        logic [31:0] w;
        mon_clear();
        start(3'd6, 4'd8);
        for (int k = 0; k < 8; k++) begin
            w = 32'hA0B0C0D0 + 32'h01010101 * k;
            send_word(w);
        end
        wait_done("wrap");
        checks += 2;
        if (we_idx_q.size() !== 8) begin
            errors++; $display("FAIL wrap_we_count: got %0d, required 8", we_idx_q.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                logic [2:0] ei;
                ei = 3'(6 + k);
                w  = 32'hA0B0C0D0 + 32'h01010101 * k;
                checks += 2;
                if (we_idx_q[k] !== ei) begin errors++; $display("FAIL wrap_idx%0d: got %0d, required %0d", k, we_idx_q[k], ei); end
                if (we_dat_q[k] !== w)  begin errors++; $display("FAIL wrap_data%0d: got %h, required %h", k, we_dat_q[k], w); end
                if (k > 0) begin
                    checks++;
                    if (we_cyc_q[k] - we_cyc_q[k-1] < 5) begin
                        errors++; $display("FAIL wrap_spacing%0d: gap %0d, required >= 5", k, we_cyc_q[k] - we_cyc_q[k-1]);
                    end
                end
            end
        end
        if (err !== 1'b0) begin errors++; $display("FAIL wrap_err: got %b, required 0", err); end
    endtask

    task automatic test_stall();
        int bad;
        bad = 0;
        mon_clear();
        start(3'd1, 4'd1);
        pgm_block = 1'b1;
        send_word(32'hCAFE0042);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pgm_we !== 1'b0 || byte_ready !== 1'b0 || busy !== 1'b1) bad++;
            step();
        end
        pgm_block = 1'b0;
        @(negedge clk);
        checks += 4;
        if (bad !== 0)   begin errors++; $display("FAIL stall_quiet: %0d bad cycles, required 0", bad); end
        if (pgm_we !== 1'b1) begin errors++; $display("FAIL stall_we: got %b, required 1", pgm_we); end
        if (pgm_idx !== 3'd1) begin errors++; $display("FAIL stall_idx: got %0d, required 1", pgm_idx); end
        if (pgm_in !== 32'hCAFE0042) begin errors++; $display("FAIL stall_data: got %h, required cafe0042", pgm_in); end
        step();
        wait_done("stall");
    endtask

    task automatic test_timeout();
        logic found;
        found = 1'b0;
        mon_clear();
        pgm_block2 = 1'b1;
        start(3'd3, 4'd1);
        send_word(32'h11223344);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            found = done2;
            step();
            if (found) break;
        end
        checks += 4;
        if (!found) begin errors++; $display("FAIL timeout_done: no done within 30 cycles, required a pulse"); end
        if (done2_cyc !== acc_cyc + 6) begin errors++; $display("FAIL timeout_cycle: done at %0d, required %0d", done2_cyc, acc_cyc + 6); end
        if (we2_cnt !== 0) begin errors++; $display("FAIL timeout_we: got %0d writes, required 0", we2_cnt); end
        if (err2 !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b, required 1", err2); end
        pgm_block2 = 1'b0;
        start(3'd0, 4'd1);
        @(negedge clk);
        checks++;
        if (err2 !== 1'b0) begin errors++; $display("FAIL timeout_err_clear: got %b, required 0", err2); end
        step();
        send_word(32'h55667788);
        wait_done("timeout_reload");
        checks++;
        if (we2_cnt !== 1) begin errors++; $display("FAIL timeout_reload_we: got %0d, required 1", we2_cnt); end
    endtask

    task automatic test_abort();
        mon_clear();
        start(3'd4, 4'd3);
        send_word(32'hDEADBEEF);
        send_byte(8'h01);
        send_byte(8'h02);
        cmd_abort = 1'b1;
        step();
        cmd_abort = 1'b0;
        @(negedge clk);
        checks += 3;
        if (done !== 1'b1) begin errors++; $display("FAIL abort_done: got %b, required 1", done); end
        if (we_idx_q.size() !== 1) begin errors++; $display("FAIL abort_we_count: got %0d, required 1", we_idx_q.size()); end
        if (err !== 1'b0) begin errors++; $display("FAIL abort_err: got %b, required 0", err); end
        step();
        start(3'd5, 4'd1);
        send_word(32'h0BADF00D);
        wait_done("abort_next");
        checks++;
        if (we_idx_q.size() !== 2) begin
            errors++; $display("FAIL abort_next_count: got %0d, required 2", we_idx_q.size());
        end else begin
            checks += 2;
            if (we_idx_q[1] !== 3'd5) begin errors++; $display("FAIL abort_next_idx: got %0d, required 5", we_idx_q[1]); end
            if (we_dat_q[1] !== 32'h0BADF00D) begin errors++; $display("FAIL abort_next_data: got %h, required 0badf00d", we_dat_q[1]); end
        end
    endtask

    task automatic test_edge_cmds();
        mon_clear();
        start(3'd0, 4'd0);
        @(negedge clk);
        checks += 3;
        if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b, required 1", done); end
        if (err !== 1'b0)  begin errors++; $display("FAIL zero_err: got %b, required 0", err); end
        if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b, required 0", busy); end
        step();
        start(3'd0, 4'd9);
        @(negedge clk);
        checks += 2;
        if (done !== 1'b1) begin errors++; $display("FAIL nine_done: got %b, required 1", done); end
        if (err !== 1'b1)  begin errors++; $display("FAIL nine_err: got %b, required 1", err); end
        step();
        start(3'd2, 4'd2);
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL start_clears_err: got %b, required 0", err); end
        step();
        send_word(32'h10203040);
        send_byte(8'hAB);
        start(3'd0, 4'd1);
        @(negedge clk);
        checks += 2;
        if (err !== 1'b1)  begin errors++; $display("FAIL busy_start_err: got %b, required 1", err); end
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_start_busy: got %b, required 1", busy); end
        step();
        send_byte(8'hCD);
        send_byte(8'hEF);
        send_byte(8'h01);
        wait_done("busy_start");
        checks += 2;
        if (we_idx_q.size() !== 2) begin
            errors++; $display("FAIL busy_start_count: got %0d, required 2", we_idx_q.size());
        end else begin
            checks += 3;
            if (we_idx_q[0] !== 3'd2) begin errors++; $display("FAIL busy_start_idx0: got %0d, required 2", we_idx_q[0]); end
            if (we_idx_q[1] !== 3'd3) begin errors++; $display("FAIL busy_start_idx1: got %0d, required 3", we_idx_q[1]); end
            if (we_dat_q[1] !== 32'hABCDEF01) begin errors++; $display("FAIL busy_start_data: got %h, required abcdef01", we_dat_q[1]); end
        end
        if (err !== 1'b1) begin errors++; $display("FAIL busy_start_sticky: got %b, required 1", err); end
        // Start and abort together in idle: the start must win.
        mon_clear();
        cmd_abort = 1'b1;
        start(3'd7, 4'd1);
        cmd_abort = 1'b0;
        @(negedge clk);
        if (busy !== 1'b1) begin errors++; $display("FAIL start_abort_busy: got %b, required 1", busy); end
        step();
        send_word(32'h77665544);
        wait_done("start_abort");
        checks++;
        if (we_idx_q.size() !== 1 || we_idx_q[0] !== 3'd7) begin
            errors++; $display("FAIL start_abort_write: got %0d writes, required one to slot 7", we_idx_q.size());
        end
    endtask

    task automatic test_reset_mid_load();
        mon_clear();
        start(3'd1, 4'd2);
        pgm_block = 1'b1;
        send_word(32'h12345678);
        rst_n = 1'b0;
        step();
        pgm_block = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (6) step();
        checks += 3;
        if (we_idx_q.size() !== 0) begin errors++; $display("FAIL rst_mid_we: got %0d, required 0", we_idx_q.size()); end
        if (done_cnt !== 0) begin errors++; $display("FAIL rst_mid_done: got %0d, required 0", done_cnt); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b, required 0", busy); end
    endtask

    initial begin
        rst_n      = 1'b0;
        cmd_start  = 1'b0;
        cmd_abort  = 1'b0;
        cmd_idx    = 3'd0;
        cmd_count  = 4'd0;
        byte_in    = 8'd0;
        byte_valid = 1'b0;
        pgm_block  = 1'b0;
        pgm_block2 = 1'b0;
        mon_clear();
        test_reset();
        test_single();
        test_wrap();
        test_stall();
        test_timeout();
        test_abort();
        test_edge_cmds();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
